// File: rtl/imem_arbiter_pkg.sv
// Shared types and constants for the instruction-memory arbiter and its RAM.
package imem_arbiter_pkg;

    typedef enum logic {
        ST_LOAD = 1'b0,
        ST_RUN  = 1'b1
    } arb_state_t;

    localparam logic [31:0] NOP_INSTR     = 32'h0000_0013;
    localparam int          DEFAULT_DEPTH = 32000;

endpackage

// File: rtl/imem_ram.sv
// Single-port instruction RAM: synchronous read, one write port, no reset on contents.
module imem_ram
    import imem_arbiter_pkg::*;
#(
    parameter int DEPTH = DEFAULT_DEPTH,
    parameter int AW    = 15
) (
    input  logic          clk,
    input  logic          en,
    input  logic          we,
    input  logic [AW-1:0] addr,
    input  logic [31:0]   wdata,
    output logic [31:0]   rdata
);

    logic [31:0] mem_array [DEPTH];
    logic [31:0] rdata_reg;

    always_ff @(posedge clk) begin
        if (en) begin
            if (we) begin
                mem_array[addr] <= wdata;
            end else begin
                rdata_reg <= mem_array[addr];
            end
        end
    end

    assign rdata = rdata_reg;

endmodule

// File: rtl/imem_arbiter.sv
// Shares the instruction BRAM port between fetch (reads) and the program loader (writes),
// holding the core in LOAD until the image is in, then favouring fetch with a starvation guard.
module imem_arbiter
    import imem_arbiter_pkg::*;
#(
    parameter int DEPTH      = DEFAULT_DEPTH,
    parameter int AW         = 15,
    parameter int STARVE_LIM = 8,
    parameter bit BOOT_LOAD  = 1'b1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          ld_valid,
    output logic          ld_ready,
    input  logic [31:0]   ld_addr,
    input  logic [31:0]   ld_data,
    input  logic          ld_done,
    input  logic          if_req,
    input  logic [31:0]   if_addr,
    output logic          if_gnt,
    output logic          if_rvalid,
    output logic [31:0]   if_rdata,
    output logic          core_hold,
    output logic          err,
    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [31:0]   mem_wdata,
    input  logic [31:0]   mem_rdata
);

    localparam int CW = $clog2(STARVE_LIM + 1);

    arb_state_t    state_reg, state_next;
    logic [CW-1:0] starve_reg, starve_next;
    logic          err_reg, err_next;
    logic          rvalid_reg;
    logic          oor_reg;
    logic [31:0]   rdata_reg;

    logic [29:0]   if_word, ld_word;
    logic          if_in_range, ld_in_range;
    logic          loader_wins, ld_accept;
    logic          unused_addr_bits;

    assign if_word          = if_addr[31:2];
    assign ld_word          = ld_addr[31:2];
    assign if_in_range      = (32'(if_word) < 32'(DEPTH));
    assign ld_in_range      = (32'(ld_word) < 32'(DEPTH));
    assign unused_addr_bits = ^{if_addr[1:0], ld_addr[1:0]};

    // Grants are suppressed while rst is high so reset never touches memory.
    always_comb begin
        state_next  = state_reg;
        starve_next = starve_reg;
        err_next    = err_reg;
        ld_ready    = 1'b0;
        if_gnt      = 1'b0;
        loader_wins = 1'b0;
        ld_accept   = 1'b0;
        mem_en      = 1'b0;
        mem_we      = 1'b0;
        mem_addr    = if_word[AW-1:0];
        mem_wdata   = ld_data;
        core_hold   = (state_reg == ST_LOAD);

        if (!rst) begin
            case (state_reg)
                ST_LOAD: begin
                    ld_ready    = 1'b1;
                    starve_next = '0;
                    if (ld_done) begin
                        state_next = ST_RUN;
                    end
                end
                ST_RUN: begin
                    loader_wins = ld_valid && (starve_reg == CW'(STARVE_LIM));
                    ld_ready    = !if_req || loader_wins;
                    if_gnt      = if_req && !loader_wins;
                    if (ld_valid && !ld_ready) begin
                        starve_next = (starve_reg == CW'(STARVE_LIM)) ? starve_reg
                                                                      : starve_reg + 1'b1;
                    end else begin
                        starve_next = '0;
                    end
                end
                default: state_next = ST_RUN;
            endcase

            ld_accept = ld_valid && ld_ready;
            if (if_gnt) begin
                mem_en   = if_in_range;
                mem_addr = if_word[AW-1:0];
            end else if (ld_accept) begin
                mem_en   = ld_in_range;
                mem_we   = ld_in_range;
                mem_addr = ld_word[AW-1:0];
            end
            err_next = err_reg | (if_gnt && !if_in_range) | (ld_accept && !ld_in_range);
        end
    end

    // Out-of-range fetches answer with a NOP instead of stale RAM data.
    assign if_rvalid = rvalid_reg && !rst;
    assign if_rdata  = if_rvalid ? (oor_reg ? NOP_INSTR : mem_rdata) : rdata_reg;
    assign err       = err_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg  <= BOOT_LOAD ? ST_LOAD : ST_RUN;
            starve_reg <= '0;
            err_reg    <= 1'b0;
            rvalid_reg <= 1'b0;
            oor_reg    <= 1'b0;
            rdata_reg  <= '0;
        end else begin
            state_reg  <= state_next;
            starve_reg <= starve_next;
            err_reg    <= err_next;
            rvalid_reg <= if_gnt;
            oor_reg    <= if_gnt && !if_in_range;
            if (if_rvalid) begin
                rdata_reg <= if_rdata;
            end
        end
    end

endmodule

// File: tb/tb_imem_arbiter.sv
// Self-checking bench for imem_arbiter driving a real imem_ram behind it.
module tb_imem_arbiter;

    localparam int DEPTH = 32000;
    localparam int AW    = 15;
    localparam int LIM   = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          ld_valid, ld_ready, ld_done;
    logic [31:0]   ld_addr, ld_data;
    logic          if_req, if_gnt, if_rvalid;
    logic [31:0]   if_addr, if_rdata;
    logic          core_hold, err;
    logic          mem_en, mem_we;
    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_wdata, mem_rdata;

    always #5 clk = ~clk;

    imem_arbiter #(
        .DEPTH(DEPTH), .AW(AW), .STARVE_LIM(LIM), .BOOT_LOAD(1'b1)
    ) dut (
        .clk(clk), .rst(rst),
        .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_addr(ld_addr),
        .ld_data(ld_data), .ld_done(ld_done),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
        .if_rvalid(if_rvalid), .if_rdata(if_rdata),
        .core_hold(core_hold), .err(err),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    imem_ram #(.DEPTH(DEPTH), .AW(AW)) ram (
        .clk(clk), .en(mem_en), .we(mem_we), .addr(mem_addr),
        .wdata(mem_wdata), .rdata(mem_rdata)
    );

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic        if_req;
        logic [31:0] if_addr;
        logic        ld_valid;
        logic [31:0] ld_addr;
        logic [31:0] ld_data;
        logic        exp_gnt;
        logic        exp_rdy;
        logic        exp_en;
        logic        exp_we;
        logic [14:0] exp_addr;
    } vec_t;

    vec_t vecs [7];

    logic [31:0] mm [16];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic ireq, input logic [31:0] ia, input logic lv,
                         input logic [31:0] la, input logic [31:0] ld, input logic dn);
        if_req   = ireq;
        if_addr  = ia;
        ld_valid = lv;
        ld_addr  = la;
        ld_data  = ld;
        ld_done  = dn;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end

    initial begin
        logic        r_req, r_lv, wins, e_rdy, e_gnt, pend_v;
        logic [31:0] ia, la, d, pend_d;
        int          iw, lw, starve;

        vecs[0] = '{1'b1, 32'h10, 1'b0, 32'h0,  32'h0,         1'b1, 1'b0, 1'b1, 1'b0, 15'd4};
        vecs[1] = '{1'b0, 32'h0,  1'b1, 32'h20, 32'hA5A5_0001, 1'b0, 1'b1, 1'b1, 1'b1, 15'd8};
        vecs[2] = '{1'b1, 32'h0,  1'b1, 32'h20, 32'hA5A5_0002, 1'b1, 1'b0, 1'b1, 1'b0, 15'd0};
        vecs[3] = '{1'b0, 32'h0,  1'b0, 32'h0,  32'h0,         1'b0, 1'b1, 1'b0, 1'b0, 15'd0};
        vecs[4] = '{1'b1, 32'h13, 1'b0, 32'h0,  32'h0,         1'b1, 1'b0, 1'b1, 1'b0, 15'd4};
        vecs[5] = '{1'b0, 32'h0,  1'b1, 32'h43, 32'hA5A5_0003, 1'b0, 1'b1, 1'b1, 1'b1, 15'd16};
        vecs[6] = '{1'b1, 32'h1F3FC, 1'b0, 32'h0, 32'h0,       1'b1, 1'b0, 1'b1, 1'b0, 15'd31999};

        // reset
        drive(0, 0, 0, 0, 0, 0);
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        @(negedge clk);
        chk("rst_core_hold", core_hold, 1);
        chk("rst_err", err, 0);
        chk("rst_rvalid", if_rvalid, 0);
        chk("rst_rdata", if_rdata, 0);
        chk("rst_ld_ready", ld_ready, 1);
        step();

        // boot load with fetch held off, last write coincides with ld_done
        drive(1, 32'h4, 1, 32'h0, 32'h1111_1111, 0);
        @(negedge clk);
        chk("load_if_gnt", if_gnt, 0);
        chk("load_mem_we", mem_we, 1);
        chk("load_mem_addr", mem_addr, 0);
        step();
        drive(1, 32'h4, 1, 32'h4, 32'h2222_2222, 1);
        @(negedge clk);
        chk("done_if_gnt", if_gnt, 0);
        chk("done_core_hold", core_hold, 1);
        chk("done_rvalid", if_rvalid, 0);
        chk("done_mem_we", mem_we, 1);
        step();
        drive(1, 32'h4, 0, 0, 0, 0);
        @(negedge clk);
        chk("run_core_hold", core_hold, 0);
        chk("run_first_gnt", if_gnt, 1);
        chk("run_first_rvalid", if_rvalid, 0);
        step();
        drive(1, 32'h0, 0, 0, 0, 0);
        @(negedge clk);
        chk("boot_rvalid_w1", if_rvalid, 1);
        chk("boot_rdata_w1", if_rdata, 32'h2222_2222);
        step();
        drive(0, 0, 0, 0, 0, 0);
        @(negedge clk);
        chk("boot_rvalid_w0", if_rvalid, 1);
        chk("boot_rdata_w0", if_rdata, 32'h1111_1111);
        step();
        @(negedge clk);
        chk("hold_rvalid", if_rvalid, 0);
        chk("hold_rdata", if_rdata, 32'h1111_1111);
        step();

        // single-cycle arbitration vectors in RUN, idle cycle between each
        for (int i = 0; i < 7; i++) begin
            drive(vecs[i].if_req, vecs[i].if_addr, vecs[i].ld_valid,
                  vecs[i].ld_addr, vecs[i].ld_data, 0);
            @(negedge clk);
            $display("vec %0d: if_gnt=%0b ld_ready=%0b mem_en=%0b mem_we=%0b mem_addr=%0d",
                     i, if_gnt, ld_ready, mem_en, mem_we, mem_addr);
            chk("vec_if_gnt", if_gnt, vecs[i].exp_gnt);
            chk("vec_ld_ready", ld_ready, vecs[i].exp_rdy);
            chk("vec_mem_en", mem_en, vecs[i].exp_en);
            chk("vec_mem_we", mem_we, vecs[i].exp_we);
            if (vecs[i].exp_en) chk("vec_mem_addr", mem_addr, vecs[i].exp_addr);
            step();
            drive(0, 0, 0, 0, 0, 0);
            step();
        end

        // starvation: loader wins on the 9th denied cycle
        drive(1, 32'h0, 1, 32'h8, 32'hDEAD_BEEF, 0);
        for (int i = 1; i <= 9; i++) begin
            @(negedge clk);
            chk("starve_ld_ready", ld_ready, (i == 9) ? 1 : 0);
            chk("starve_if_gnt", if_gnt, (i == 9) ? 0 : 1);
            if (i == 9) begin
                chk("starve_mem_we", mem_we, 1);
                chk("starve_mem_addr", mem_addr, 2);
            end
            step();
        end
        drive(1, 32'h0, 0, 0, 0, 0);
        @(negedge clk);
        chk("starve_regain_gnt", if_gnt, 1);
        step();
        drive(1, 32'h8, 0, 0, 0, 0);
        step();
        drive(0, 0, 0, 0, 0, 0);
        @(negedge clk);
        chk("starve_rb_rvalid", if_rvalid, 1);
        chk("starve_rb_rdata", if_rdata, 32'hDEAD_BEEF);
        step();

        // out-of-range fetch and loader write
        @(negedge clk);
        chk("oor_err_before", err, 0);
        drive(1, 32'h1F400, 0, 0, 0, 0);
        @(negedge clk);
        chk("oor_if_gnt", if_gnt, 1);
        chk("oor_if_mem_en", mem_en, 0);
        step();
        drive(0, 0, 0, 0, 0, 0);
        @(negedge clk);
        chk("oor_rvalid", if_rvalid, 1);
        chk("oor_rdata_nop", if_rdata, 32'h0000_0013);
        chk("oor_err_set", err, 1);
        step();
        drive(0, 0, 1, 32'h1F400, 32'h0BAD_0BAD, 0);
        @(negedge clk);
        chk("oor_ld_ready", ld_ready, 1);
        chk("oor_ld_mem_en", mem_en, 0);
        chk("oor_ld_mem_we", mem_we, 0);
        step();
        drive(0, 0, 0, 0, 0, 0);
        @(negedge clk);
        chk("oor_err_sticky", err, 1);
        step();

        // preload words 0..15 with known data for the random phase
        for (int w = 0; w < 16; w++) begin
            mm[w] = $urandom;
            drive(0, 0, 1, 32'(w * 4), mm[w], 0);
            @(negedge clk);
            chk("preload_ld_ready", ld_ready, 1);
            step();
        end
        drive(0, 0, 0, 0, 0, 0);
        step();

        // random traffic against a reference model
        starve = 0;
        pend_v = 1'b0;
        pend_d = '0;
        for (int n = 0; n < 400; n++) begin
            r_req = ($urandom_range(9) < 7);
            r_lv  = ($urandom_range(1) == 1);
            iw    = $urandom_range(15);
            if ($urandom_range(15) == 0) iw = DEPTH + $urandom_range(3);
            lw    = $urandom_range(15);
            ia    = 32'(iw * 4) | 32'($urandom_range(3));
            la    = 32'(lw * 4) | 32'($urandom_range(3));
            d     = $urandom;
            drive(r_req, ia, r_lv, la, d, 0);
            wins  = r_lv && (starve == LIM);
            e_rdy = !r_req || wins;
            e_gnt = r_req && !wins;
            @(negedge clk);
            chk("rnd_rvalid", if_rvalid, pend_v);
            if (pend_v) chk("rnd_rdata", if_rdata, pend_d);
            chk("rnd_ld_ready", ld_ready, e_rdy);
            chk("rnd_if_gnt", if_gnt, e_gnt);
            pend_v = e_gnt;
            pend_d = (iw >= DEPTH) ? 32'h0000_0013 : mm[iw];
            if (r_lv && e_rdy) mm[lw] = d;
            starve = (r_lv && !e_rdy) ? ((starve < LIM) ? starve + 1 : LIM) : 0;
            step();
        end
        drive(0, 0, 0, 0, 0, 0);
        @(negedge clk);
        chk("rnd_tail_rvalid", if_rvalid, pend_v);
        if (pend_v) chk("rnd_tail_rdata", if_rdata, pend_d);
        chk("rnd_err", err, 1);
        step();

        // reset the cycle after a grant: the in-flight read must vanish
        drive(1, 32'h4, 0, 0, 0, 0);
        @(negedge clk);
        chk("mid_gnt", if_gnt, 1);
        step();
        drive(0, 0, 0, 0, 0, 0);
        rst = 1'b1;
        @(negedge clk);
        chk("mid_rst_rvalid", if_rvalid, 0);
        step();
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_rvalid", if_rvalid, 0);
        chk("post_rst_core_hold", core_hold, 1);
        chk("post_rst_err", err, 0);
        chk("post_rst_rdata", if_rdata, 0);
        step();
        drive(0, 0, 0, 0, 0, 1);
        step();
        drive(1, 32'h4, 0, 0, 0, 0);
        @(negedge clk);
        chk("reload_gnt", if_gnt, 1);
        step();
        drive(0, 0, 0, 0, 0, 0);
        @(negedge clk);
        chk("reload_rvalid", if_rvalid, 1);
        chk("reload_rdata", if_rdata, mm[1]);
        step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
